// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic DEPTH-slot ready/valid pipeline register carrying a
// control bundle and a data bundle between CPU stages. Supports backpressure
// and a synchronous flush that kills in-flight control state.
// Optional statistics (stall_cnt/flush_cnt) are built when PIPE_STAT_EN is defined.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CTRL_W = 11,
  parameter int unsigned DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  // Slot 0 is the input side, slot DEPTH-1 drives the outputs.
  logic [DEPTH-1:0]  v_q;
  logic [DEPTH-1:0]  v_d;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic [DEPTH-1:0]  mv;
  logic [DEPTH-1:0]  load;
  logic              accept;

  // Move/load chain: resolved from the output side back to the input so that
  // out_ready ripples combinationally into in_ready.
  always_comb begin
    mv   = '0;
    load = '0;
    mv[DEPTH-1] = v_q[DEPTH-1] & out_ready;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      mv[DEPTH-1-i] = v_q[DEPTH-1-i] & (~v_q[DEPTH-i] | mv[DEPTH-i]);
    end
    for (int unsigned k = 1; k < DEPTH; k++) begin
      load[k] = v_q[k-1] & (~v_q[k] | mv[k]);
    end
    in_ready = flush | ~v_q[0] | mv[0];
    accept   = in_valid & in_ready;
    load[0]  = accept;
  end

  // Next-state per slot; flush kills every slot (the output handshake in the
  // flush cycle still completes because the outgoing beat is already on out_*).
  always_comb begin
    v_d[0]    = v_q[0];
    ctrl_d[0] = ctrl_q[0];
    data_d[0] = data_q[0];
    if (flush) begin
      v_d[0]    = 1'b0;
      ctrl_d[0] = '0;
    end else if (load[0]) begin
      v_d[0]    = 1'b1;
      ctrl_d[0] = in_ctrl;
      data_d[0] = in_data;
    end else if (mv[0]) begin
      v_d[0]    = 1'b0;
      ctrl_d[0] = '0;
    end

    for (int unsigned k = 1; k < DEPTH; k++) begin
      v_d[k]    = v_q[k];
      ctrl_d[k] = ctrl_q[k];
      data_d[k] = data_q[k];
      if (flush) begin
        v_d[k]    = 1'b0;
        ctrl_d[k] = '0;
      end else if (load[k]) begin
        v_d[k]    = 1'b1;
        ctrl_d[k] = ctrl_q[k-1];
        data_d[k] = data_q[k-1];
      end else if (mv[k]) begin
        v_d[k]    = 1'b0;
        ctrl_d[k] = '0;
      end
    end
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        ctrl_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        ctrl_q[k] <= ctrl_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_ctrl  = ctrl_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

`ifdef PIPE_STAT_EN
  logic [15:0]      stall_cnt_q;
  logic [15:0]      stall_cnt_d;
  logic [15:0]      flush_cnt_q;
  logic [15:0]      flush_cnt_d;
  logic [DEPTH-1:0] live;
  logic             kill;

  // Saturating statistics; a flush counts only if it kills a slot that is not
  // leaving through the output handshake, or an input beat.
  always_comb begin
    live            = v_q;
    live[DEPTH-1]   = v_q[DEPTH-1] & ~out_ready;
    kill            = flush & (in_valid | (|live));
    stall_cnt_d     = stall_cnt_q;
    flush_cnt_d     = flush_cnt_q;
    if (in_valid & ~in_ready & ~flush & (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (kill & (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: a DEPTH=2 instance (u_d2)
// and a DEPTH=3 instance (u_d3). Statistics checks build with PIPE_STAT_EN.
module tb_pipe_stage_reg;

  logic clk;
  logic rst;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [10:0] a_in_ctrl, a_out_ctrl;
  logic [31:0] a_in_data, a_out_data;
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [10:0] b_in_ctrl, b_out_ctrl;
  logic [31:0] b_in_data, b_out_data;
`ifdef PIPE_STAT_EN
  logic [15:0] a_stall, a_fcnt, b_stall, b_fcnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(11), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data)
`ifdef PIPE_STAT_EN
    , .stall_cnt(a_stall), .flush_cnt(a_fcnt)
`endif
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(11), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data)
`ifdef PIPE_STAT_EN
    , .stall_cnt(b_stall), .flush_cnt(b_fcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_d2_valid: got %b want 0", a_out_valid); end
    n_checks++; if (a_out_ctrl !== 11'h0) begin n_fail++; $display("FAIL reset_d2_ctrl: got %h want 000", a_out_ctrl); end
    n_checks++; if (a_out_data !== 32'h0) begin n_fail++; $display("FAIL reset_d2_data: got %h want 0", a_out_data); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_d2_in_ready: got %b want 1", a_in_ready); end
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_d3_valid: got %b want 0", b_out_valid); end
    n_checks++; if (b_out_ctrl !== 11'h0) begin n_fail++; $display("FAIL reset_d3_ctrl: got %h want 000", b_out_ctrl); end
    n_checks++; if (b_out_data !== 32'h0) begin n_fail++; $display("FAIL reset_d3_data: got %h want 0", b_out_data); end
    n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_d3_in_ready: got %b want 1", b_in_ready); end
`ifdef PIPE_STAT_EN
    n_checks++; if (a_stall !== 16'h0) begin n_fail++; $display("FAIL reset_stall_cnt: got %h want 0", a_stall); end
    n_checks++; if (b_fcnt !== 16'h0) begin n_fail++; $display("FAIL reset_flush_cnt: got %h want 0", b_fcnt); end
`endif
  endtask

  // DEPTH=2: beats 1,2,3 presented in cycles 0..2 appear in cycles 2..4.
  task automatic test_streaming();
    logic        ev;
    logic [31:0] ed;
    a_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      a_in_valid = (i < 3);
      a_in_data  = 32'(i + 1);
      a_in_ctrl  = 11'(i + 1);
      #1;
      ev = (i >= 2 && i <= 4);
      ed = (i < 2) ? 32'h0 : (i == 5) ? 32'h3 : 32'(i - 1);
      n_checks++; if (a_out_valid !== ev) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want %b", i, a_out_valid, ev); end
      n_checks++; if (a_out_data !== ed) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, a_out_data, ed); end
      n_checks++; if (a_out_ctrl !== (ev ? 11'(i - 1) : 11'h0)) begin n_fail++; $display("FAIL stream_ctrl[%0d]: got %h want %h", i, a_out_ctrl, ev ? 11'(i - 1) : 11'h0); end
      n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, a_in_ready); end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    cyc(); a_in_valid = 1'b1; a_in_data = 32'hA; a_in_ctrl = 11'h0A; #1;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready0: got %b want 1", a_in_ready); end
    cyc(); a_in_data = 32'hB; a_in_ctrl = 11'h0B; #1;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1: got %b want 1", a_in_ready); end
    cyc(); a_in_data = 32'hC; a_in_ctrl = 11'h0C; #1;
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", a_in_ready); end
    n_checks++; if (a_out_data !== 32'hA) begin n_fail++; $display("FAIL bp_head: got %h want A", a_out_data); end
    cyc(); #1;
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_still_full: got %b want 0", a_in_ready); end
    cyc(); a_out_ready = 1'b1; #1;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_passthrough: got %b want 1", a_in_ready); end
    n_checks++; if (a_out_data !== 32'hA) begin n_fail++; $display("FAIL bp_out_a: got %h want A", a_out_data); end
    cyc(); a_in_valid = 1'b0; #1;
    n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hB) begin n_fail++; $display("FAIL bp_out_b: got v=%b d=%h want v=1 d=B", a_out_valid, a_out_data); end
`ifdef PIPE_STAT_EN
    n_checks++; if (a_stall !== 16'd2) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d want 2", a_stall); end
`endif
    cyc(); #1;
    n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hC) begin n_fail++; $display("FAIL bp_out_c: got v=%b d=%h want v=1 d=C", a_out_valid, a_out_data); end
    cyc(); #1;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", a_out_valid); end
  endtask

  // DEPTH=3: four beats back to back, each appearing three cycles later.
  task automatic test_back_to_back();
    logic ev;
    b_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      b_in_valid = (i < 4);
      b_in_data  = 32'h20 + 32'(i);
      b_in_ctrl  = 11'h40 + 11'(i);
      #1;
      ev = (i >= 3 && i <= 6);
      n_checks++; if (b_out_valid !== ev) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, b_out_valid, ev); end
      n_checks++; if (b_out_ctrl !== (ev ? 11'h40 + 11'(i - 3) : 11'h0)) begin n_fail++; $display("FAIL b2b_ctrl[%0d]: got %h want %h", i, b_out_ctrl, ev ? 11'h40 + 11'(i - 3) : 11'h0); end
      if (ev) begin
        n_checks++; if (b_out_data !== 32'h20 + 32'(i - 3)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, b_out_data, 32'h20 + 32'(i - 3)); end
      end
    end
    b_in_valid = 1'b0;
  endtask

  task automatic test_flush();
    b_out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cyc();
      b_in_valid = 1'b1;
      b_in_ctrl  = 11'h7FF;
      b_in_data  = 32'h100 + 32'(j);
      #1;
      n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_fill_ready[%0d]: got %b want 1", j, b_in_ready); end
    end
    cyc(); b_flush = 1'b1; b_out_ready = 1'b1; b_in_data = 32'h103; #1;
    n_checks++; if (b_out_valid !== 1'b1 || b_out_data !== 32'h100 || b_out_ctrl !== 11'h7FF) begin
      n_fail++; $display("FAIL flush_oldest: got v=%b d=%h c=%h want v=1 d=100 c=7ff", b_out_valid, b_out_data, b_out_ctrl);
    end
    n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", b_in_ready); end
    for (int j = 0; j < 3; j++) begin
      cyc(); b_flush = 1'b0; b_in_valid = 1'b0; #1;
      n_checks++; if (b_out_valid !== 1'b0 || b_out_ctrl !== 11'h0) begin
        n_fail++; $display("FAIL flush_killed[%0d]: got v=%b c=%h want v=0 c=000", j, b_out_valid, b_out_ctrl);
      end
    end
`ifdef PIPE_STAT_EN
    n_checks++; if (b_fcnt !== 16'd1) begin n_fail++; $display("FAIL flush_cnt: got %0d want 1", b_fcnt); end
`endif
  endtask

  task automatic test_flush_empty();
    cyc(); b_flush = 1'b1; b_in_valid = 1'b0; #1;
    n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty_ready: got %b want 1", b_in_ready); end
    cyc(); b_flush = 1'b0; #1;
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_valid: got %b want 0", b_out_valid); end
`ifdef PIPE_STAT_EN
    n_checks++; if (b_fcnt !== 16'd1) begin n_fail++; $display("FAIL flush_empty_cnt: got %0d want 1", b_fcnt); end
`endif
  endtask

`ifdef PIPE_STAT_EN
  task automatic test_saturation();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h77;
    repeat (70000) cyc();
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL sat_ready: got %b want 0", a_in_ready); end
    n_checks++; if (a_stall !== 16'hFFFF) begin n_fail++; $display("FAIL sat_stall: got %h want ffff", a_stall); end
    repeat (5) cyc();
    n_checks++; if (a_stall !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", a_stall); end
  endtask
`endif

  task automatic test_reset_vs_flush();
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    cyc();
    a_in_valid = 1'b1; a_in_data = 32'h55; a_in_ctrl = 11'h7FF;
    b_in_valid = 1'b1; b_in_data = 32'h55; b_in_ctrl = 11'h7FF;
    cyc(); cyc(); cyc(); #1;
    n_checks++; if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0) begin n_fail++; $display("FAIL rvf_full: got v=%b r=%b want v=1 r=0", b_out_valid, b_in_ready); end
    rst = 1'b1; a_flush = 1'b1; b_flush = 1'b1; a_out_ready = 1'b1; b_out_ready = 1'b1;
    cyc();
    rst = 1'b0; a_flush = 1'b0; b_flush = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
    #1;
    n_checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 11'h0 || a_out_data !== 32'h0) begin
      n_fail++; $display("FAIL rvf_d2: got v=%b c=%h d=%h want all 0", a_out_valid, a_out_ctrl, a_out_data);
    end
    n_checks++; if (b_out_valid !== 1'b0 || b_out_ctrl !== 11'h0 || b_out_data !== 32'h0) begin
      n_fail++; $display("FAIL rvf_d3: got v=%b c=%h d=%h want all 0", b_out_valid, b_out_ctrl, b_out_data);
    end
    n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL rvf_ready: got %b want 1", b_in_ready); end
    cyc(); #1;
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL rvf_stays_empty: got %b want 0", b_out_valid); end
`ifdef PIPE_STAT_EN
    n_checks++; if (b_fcnt !== 16'h0) begin n_fail++; $display("FAIL rvf_flush_cnt: got %0d want 0", b_fcnt); end
    n_checks++; if (a_stall !== 16'h0) begin n_fail++; $display("FAIL rvf_stall_cnt: got %0d want 0", a_stall); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_ctrl = '0; a_in_data = '0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_ctrl = '0; b_in_data = '0; b_out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_flush_empty();
`ifdef PIPE_STAT_EN
    test_saturation();
`endif
    test_reset_vs_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
